cla_mul_seq: RTL and testbench
==============================

// Module: cla_mul_seq
// PURPOSE
//  Multi-cycle shift-add multiplier sequencer. Owns no adder of its own: it drives
//  one external combinational 32-bit carry-lookahead adder (same cycle, d1+d2+cin)
//  and iterates it to form a 2*WIDTH product. Supports unsigned and signed
//  (two's complement) operands. Signed mode negates values on the same adder.
//  Sits beside the ALU adder; the ALU issues start/op and collects result on done.
// PARAMETERS
//  WIDTH  32  operand width; must equal the external adder width (>=2)
// PORTS
//  clk        in   1        rising-edge clock, single clock domain
//  rst        in   1        synchronous, active-high reset
//  start      in   1        request; accepted only when busy==0
//  op_signed  in   1        1: signed operands, 0: unsigned; sampled at accept
//  mcand      in   WIDTH    multiplicand, sampled at accept
//  mplier     in   WIDTH    multiplier, sampled at accept
//  busy       out  1        high from the cycle after accept until the last compute cycle
//  done       out  1        one-cycle pulse, result valid
//  result     out  2*WIDTH  product; held until the next accepted start's done
//  add_a      out  WIDTH    adder operand d1
//  add_b      out  WIDTH    adder operand d2
//  add_cin    out  1        adder carry-in
//  add_sum    in   WIDTH    adder sum (combinational from add_a/add_b/add_cin)
//  add_cout   in   1        adder carry-out
// BEHAVIOUR
//  Reset (any state, incl. mid-op): state=IDLE, busy=0, done=0, result=0, count=0,
//   internal regs=0. No partial op survives reset.
//  States: IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI.
//  IDLE: add_a=add_b=0, add_cin=0. On start: latch A=mcand, B=mplier, sgn=op_signed,
//   neg=op_signed&(mcand[W-1]^mplier[W-1]), hi=0, count=0.
//   Next state is NEG_A if op_signed, else ITER with lo=mplier.
//  NEG_A: add_a=~A, add_b=0, add_cin=1. If A[W-1], A<=add_sum (|A|).
//   Most-negative value stays 0x80..0, which is the correct unsigned magnitude.
//  NEG_B: same on B. Then lo<=|B|, ->ITER.
//  ITER (exactly WIDTH cycles): add_a=hi, add_b=lo[0]?A:0, add_cin=0;
//   hi<={add_cout,add_sum[W-1:1]}, lo<={add_sum[0],lo[W-1:1]}, count++.
//   After count==WIDTH-1: go to NEG_LO if sgn, else finish.
//  NEG_LO: add_a=~lo, add_b=0, add_cin=1. If neg: lo<=add_sum and latch c=add_cout.
//   If !neg: c=0, regs unchanged.
//  NEG_HI: add_a=~hi, add_b=0, add_cin=c. If neg: hi<=add_sum. Then finish.
//  Finish: result<={hi,lo}, done<=1, state<=IDLE (registered; visible next cycle).
//  Fixed latency, accept at cycle T:
//   unsigned: done=1 at T+WIDTH+1.
//   signed:   done=1 at T+WIDTH+5.
//   Negate states are always traversed in signed mode, even if operands are positive.
//  busy=1 in every non-IDLE state. done=1 only in the IDLE cycle following finish.
//  start while busy: ignored, no latch, no queueing.
//  start in the done cycle: accepted (state is IDLE); result keeps the old value
//   until the new done.
//  All regs update only on clk; no combinational path from start to add_* outputs.
// TESTING
//  1 unsigned 0xFFFFFFFF*0xFFFFFFFF, accept T -> done@T+33,
//    result=0xFFFFFFFE_00000001, busy=1 for T+1..T+32.
//  2 signed -3(0xFFFFFFFD)*7 -> done@T+37, result=0xFFFFFFFF_FFFFFFEB;
//    signed 5*6 -> 0x1E, also done@T+37.
//  3 signed 0x80000000*0x80000000 -> 0x40000000_00000000;
//    signed 0x80000000*1 -> 0xFFFFFFFF_80000000.
//  4 start pulsed at T+5 of a running op -> ignored, first result unchanged;
//    start in the done cycle -> accepted, next done 33 cycles later.
//  5 rst asserted mid-ITER -> next cycle busy=0, done=0, result=0;
//    following unsigned 12*10 -> 0x78.
//  6 bench adder model checks add_cin=0 in every ITER cycle and add_cin=1 in
//    NEG_A/NEG_B/NEG_LO; 1000 random signed/unsigned ops match a reference product.

Source files
------------

// File: rtl/cla_mul_seq.sv
//============================================================================
// Module      : cla_mul_seq
// Description : Multi-cycle shift-add multiplier sequencer. It has no adder
//               of its own. It drives one external combinational WIDTH-bit
//               adder (sum = d1 + d2 + cin, same cycle) and iterates it to
//               form a 2*WIDTH product. Operands may be unsigned or two's
//               complement. Signed operands are negated to magnitudes and the
//               product is negated back, all on the same external adder.
// Ports       : clk, rst          clock, synchronous active-high reset
//               start, op_signed  request and operand mode (taken on accept)
//               mcand, mplier     operands (taken on accept)
//               busy, done        status; done is a one-cycle result pulse
//               result            2*WIDTH product, held until the next done
//               add_a/b/cin       operands driven to the external adder
//               add_sum/cout      external adder response
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module cla_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NEG_A  = 3'd1,
        S_NEG_B  = 3'd2,
        S_ITER   = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_a, w_a_nxt;
    logic [WIDTH-1:0]     r_b, w_b_nxt;
    logic [WIDTH-1:0]     r_hi, w_hi_nxt;
    logic [WIDTH-1:0]     r_lo, w_lo_nxt;
    logic                 r_sgn, w_sgn_nxt;
    logic                 r_neg, w_neg_nxt;
    logic                 r_c, w_c_nxt;
    logic [c_cnt_w-1:0]   r_count, w_count_nxt;
    logic                 r_done, w_done_nxt;
    logic [2*WIDTH-1:0]   r_result, w_result_nxt;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_sgn    <= 1'b0;
            r_neg    <= 1'b0;
            r_c      <= 1'b0;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_sgn    <= w_sgn_nxt;
            r_neg    <= w_neg_nxt;
            r_c      <= w_c_nxt;
            r_count  <= w_count_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
        end
    end

    // Next-state, adder operand and datapath update logic. The adder operands
    // depend only on registered state, so start never reaches add_* directly.
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_sgn_nxt    = r_sgn;
        w_neg_nxt    = r_neg;
        w_c_nxt      = r_c;
        w_count_nxt  = r_count;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
        add_a        = '0;
        add_b        = '0;
        add_cin      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_nxt     = mcand;
                    w_b_nxt     = mplier;
                    w_sgn_nxt   = op_signed;
                    w_neg_nxt   = op_signed & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
                    w_hi_nxt    = '0;
                    w_c_nxt     = 1'b0;
                    w_count_nxt = '0;
                    if (op_signed) begin
                        w_state_nxt = S_NEG_A;
                    end else begin
                        w_lo_nxt    = mplier;
                        w_state_nxt = S_ITER;
                    end
                end
            end

            // ~x + 1 gives |x| for negative x. The most negative value maps to
            // itself, which is already its correct unsigned magnitude.
            S_NEG_A: begin
                add_a   = ~r_a;
                add_cin = 1'b1;
                if (r_a[WIDTH-1]) begin
                    w_a_nxt = add_sum;
                end
                w_state_nxt = S_NEG_B;
            end

            S_NEG_B: begin
                add_a   = ~r_b;
                add_cin = 1'b1;
                if (r_b[WIDTH-1]) begin
                    w_b_nxt  = add_sum;
                    w_lo_nxt = add_sum;
                end else begin
                    w_lo_nxt = r_b;
                end
                w_state_nxt = S_ITER;
            end

            // One shift-add step: hi += lo[0] ? A : 0, then shift {cout,hi,lo}
            // right by one. The consumed multiplier bit falls out of lo.
            S_ITER: begin
                add_a       = r_hi;
                add_b       = r_lo[0] ? r_a : '0;
                w_hi_nxt    = {add_cout, add_sum[WIDTH-1:1]};
                w_lo_nxt    = {add_sum[0], r_lo[WIDTH-1:1]};
                w_count_nxt = r_count + 1'b1;
                if (r_count == c_cnt_last) begin
                    if (r_sgn) begin
                        w_state_nxt = S_NEG_LO;
                    end else begin
                        w_result_nxt = {w_hi_nxt, w_lo_nxt};
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end

            // Two-word negate: low half first, its carry-out feeds the high half.
            S_NEG_LO: begin
                add_a   = ~r_lo;
                add_cin = 1'b1;
                if (r_neg) begin
                    w_lo_nxt = add_sum;
                    w_c_nxt  = add_cout;
                end else begin
                    w_c_nxt  = 1'b0;
                end
                w_state_nxt = S_NEG_HI;
            end

            S_NEG_HI: begin
                add_a   = ~r_hi;
                add_cin = r_c;
                if (r_neg) begin
                    w_hi_nxt = add_sum;
                end
                w_result_nxt = {w_hi_nxt, r_lo};
                w_done_nxt   = 1'b1;
                w_state_nxt  = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_cla_mul_seq.sv
//============================================================================
// Module      : tb_cla_mul_seq
// Description : Self-checking bench for cla_mul_seq. Provides the external
//               combinational adder, applies directed vectors with known
//               products and then a batch of random signed/unsigned operands
//               checked against a reference product. Latency, busy, done,
//               held result and adder carry-in are checked cycle by cycle.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_cla_mul_seq;

    localparam int WIDTH = 32;

    logic                clk;
    logic                rst;
    logic                start;
    logic                op_signed;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    mplier;
    logic                busy;
    logic                done;
    logic [2*WIDTH-1:0]  result;
    logic [WIDTH-1:0]    add_a;
    logic [WIDTH-1:0]    add_b;
    logic                add_cin;
    logic [WIDTH-1:0]    add_sum;
    logic                add_cout;

    int                  n_vec;
    int                  n_err;
    logic [2*WIDTH-1:0]  m_result;

    cla_mul_seq #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_signed (op_signed),
        .mcand     (mcand),
        .mplier    (mplier),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // External adder model
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Issues one operation in the current cycle (caller sits #1 after an edge)
    // and follows it to its done cycle, where it returns without advancing.
    // With poke set, a second start is pulsed at T+5 and must be ignored.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit poke);
        int           lat;
        logic [31:0]  ma;
        logic [31:0]  mb;
        logic [63:0]  mag;
        logic         exp_cin;
        lat = sgn ? 37 : 33;
        ma  = (sgn && a[31]) ? (32'd0 - a) : a;
        mb  = (sgn && b[31]) ? (32'd0 - b) : b;
        mag = {32'b0, ma} * {32'b0, mb};

        check_eq("accept_busy", {63'b0, busy}, 64'd0);
        start     = 1'b1;
        op_signed = sgn;
        mcand     = a;
        mplier    = b;
        @(posedge clk); #1;
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        for (int k = 1; k <= lat; k++) begin
            if (k < lat) begin
                check_eq("busy", {63'b0, busy}, 64'd1);
                check_eq("done_early", {63'b0, done}, 64'd0);
                if (!sgn)         exp_cin = 1'b0;
                else if (k <= 2)  exp_cin = 1'b1;
                else if (k <= 34) exp_cin = 1'b0;
                else if (k == 35) exp_cin = 1'b1;
                else              exp_cin = (a[31] ^ b[31]) && (mag[31:0] == 32'd0);
                check_eq("add_cin", {63'b0, add_cin}, {63'b0, exp_cin});
                if (sgn && k == 1) check_eq("neg_a_operand", {32'b0, add_a}, {32'b0, ~a});
                if (k == lat - 1)  check_eq("result_held", result, m_result);
            end else begin
                check_eq("done", {63'b0, done}, 64'd1);
                check_eq("busy_at_done", {63'b0, busy}, 64'd0);
                check_eq("result", result, exp);
                m_result = exp;
            end
            if (poke && k == 5) begin
                start     = 1'b1;
                op_signed = ~sgn;
                mcand     = 32'h0000_0003;
                mplier    = 32'h0000_0009;
            end else begin
                start = 1'b0;
            end
            if (k < lat) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        logic        r_sgn;
        logic [31:0] r_a;
        logic [31:0] r_b;
        n_vec     = 0;
        n_err     = 0;
        m_result  = '0;
        rst       = 1'b1;
        start     = 1'b0;
        op_signed = 1'b0;
        mcand     = '0;
        mplier    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", {63'b0, busy}, 64'd0);
        check_eq("rst_done", {63'b0, done}, 64'd0);
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_add_a", {32'b0, add_a}, 64'd0);
        check_eq("rst_add_b", {32'b0, add_b}, 64'd0);
        check_eq("rst_add_cin", {63'b0, add_cin}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed products; consecutive calls accept in the previous done cycle
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op(1'b1, 32'h0000_0005, 32'h0000_0006, 64'h0000_0000_0000_001E, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0);
        run_op(1'b0, 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060, 1'b1);
        run_op(1'b0, 32'h0000_0003, 32'h0000_0004, 64'h0000_0000_0000_000C, 1'b0);
        run_op(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 1'b0);

        // Reset in the middle of an iteration
        @(posedge clk); #1;
        start     = 1'b1;
        op_signed = 1'b0;
        mcand     = 32'hDEAD_BEEF;
        mplier    = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_busy", {63'b0, busy}, 64'd0);
        check_eq("midrst_done", {63'b0, done}, 64'd0);
        check_eq("midrst_result", result, 64'd0);
        m_result = '0;
        run_op(1'b0, 32'd12, 32'd10, 64'h0000_0000_0000_0078, 1'b0);

        // Random operands against the reference product
        for (int i = 0; i < 1000; i++) begin
            r_sgn = 1'($urandom_range(0, 1));
            r_a   = $urandom;
            r_b   = $urandom;
            if (i % 50 == 0) r_a = 32'h8000_0000;
            if (i % 70 == 0) r_b = 32'hFFFF_FFFF;
            run_op(r_sgn, r_a, r_b, ref_mul(r_sgn, r_a, r_b), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
